// File: rtl/cache_control_pkg.sv
// Shared types for the L1 cache controller: FSM state encoding and datapath mux selects.
package cache_types;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    localparam logic SRC_CPU  = 1'b0;
    localparam logic SRC_PMEM = 1'b1;
    localparam logic ADDR_CPU = 1'b0;
    localparam logic ADDR_WB  = 1'b1;

endpackage

// File: rtl/cache_control_perf_counters.sv
// Hit/miss/writeback event counters for the cache controller; built only with CACHE_PERF_COUNTERS_EN.
module cache_perf_counters #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_resp,
    input  logic               miss_start,
    input  logic               wb_done,
    input  logic               alloc_done,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count,
    output logic [COUNT_W-1:0] wb_count
);

    logic               refill_q, refill_d;
    logic [COUNT_W-1:0] hit_q, hit_d;
    logic [COUNT_W-1:0] miss_q, miss_d;
    logic [COUNT_W-1:0] wb_q, wb_d;

    // The response right after a line fill completes a miss, so it is not a first-pass hit.
    always_comb begin
        refill_d = alloc_done;
        hit_d    = hit_q;
        miss_d   = miss_q;
        wb_d     = wb_q;
        if (mem_resp && !refill_q) begin
            hit_d = hit_q + COUNT_W'(1);
        end
        if (miss_start) begin
            miss_d = miss_q + COUNT_W'(1);
        end
        if (wb_done) begin
            wb_d = wb_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refill_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            wb_q     <= '0;
        end else begin
            refill_q <= refill_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            wb_q     <= wb_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative L1 cache: hits, dirty writeback, line allocation.
// Optional performance counters are compiled in with CACHE_PERF_COUNTERS_EN.
module cache_control
    import cache_types::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               hit,
    input  logic               hit_way,
    input  logic               dirty0,
    input  logic               dirty1,
    input  logic               pmem_resp,
    output logic               mem_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic               way_sel,
    output logic               load_data,
    output logic               load_tag,
    output logic               load_valid,
    output logic               load_dirty,
    output logic               load_lru,
    output logic               dirty_in,
    output logic               lru_in,
    output logic               data_src_sel,
    output logic               pmem_addr_sel
`ifdef CACHE_PERF_COUNTERS_EN
   ,output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count,
    output logic [COUNT_W-1:0] wb_count
`endif
);

    cache_state_t state_q, state_d;
    logic         victim_q, victim_d;
    logic         miss_start, wb_done, alloc_done;
    logic         req;

    assign req = mem_read | mem_write;

    // Outputs are decoded from state and inputs; reset forces them low without waiting for an edge.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        miss_start    = 1'b0;
        wb_done       = 1'b0;
        alloc_done    = 1'b0;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        way_sel       = 1'b0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        load_lru      = 1'b0;
        dirty_in      = 1'b0;
        lru_in        = 1'b0;
        data_src_sel  = SRC_CPU;
        pmem_addr_sel = ADDR_CPU;
        if (!rst) begin
            unique case (state_q)
                CHECK: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~hit_way;
                        if (mem_write) begin
                            way_sel      = hit_way;
                            load_data    = 1'b1;
                            data_src_sel = SRC_CPU;
                            load_dirty   = 1'b1;
                            dirty_in     = 1'b1;
                        end
                    end else if (req) begin
                        // Victim is captured here and held for the whole miss.
                        victim_d   = hit_way;
                        miss_start = 1'b1;
                        state_d    = (hit_way ? dirty1 : dirty0) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = ADDR_WB;
                    way_sel       = victim_q;
                    if (pmem_resp) begin
                        wb_done = 1'b1;
                        state_d = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    pmem_read     = 1'b1;
                    pmem_addr_sel = ADDR_CPU;
                    way_sel       = victim_q;
                    if (pmem_resp) begin
                        load_data    = 1'b1;
                        data_src_sel = SRC_PMEM;
                        load_tag     = 1'b1;
                        load_valid   = 1'b1;
                        load_dirty   = 1'b1;
                        dirty_in     = 1'b0;
                        alloc_done   = 1'b1;
                        state_d      = CHECK;
                    end
                end
                default: state_d = CHECK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CHECK;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

`ifdef CACHE_PERF_COUNTERS_EN
    cache_perf_counters #(
        .COUNT_W (COUNT_W)
    ) u_perf (
        .clk        (clk),
        .rst        (rst),
        .mem_resp   (mem_resp),
        .miss_start (miss_start),
        .wb_done    (wb_done),
        .alloc_done (alloc_done),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );
`else
    logic unused_events;
    assign unused_events = ^{wb_done, alloc_done, miss_start};
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: hits, clean/dirty misses, async reset, stray responses.
module tb_cache_control;
    import cache_types::*;

    localparam int unsigned COUNT_W = 32;

    // Output vector bit weights: {mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag,
    // load_valid, load_dirty, load_lru, dirty_in, lru_in, data_src_sel, pmem_addr_sel}
    localparam logic [12:0] MR   = 13'h1000;
    localparam logic [12:0] PR   = 13'h0800;
    localparam logic [12:0] PW   = 13'h0400;
    localparam logic [12:0] WS   = 13'h0200;
    localparam logic [12:0] LD   = 13'h0100;
    localparam logic [12:0] LT   = 13'h0080;
    localparam logic [12:0] LV   = 13'h0040;
    localparam logic [12:0] LDY  = 13'h0020;
    localparam logic [12:0] LLRU = 13'h0010;
    localparam logic [12:0] DIN  = 13'h0008;
    localparam logic [12:0] LRUI = 13'h0004;
    localparam logic [12:0] DSS  = 13'h0002;
    localparam logic [12:0] PAS  = 13'h0001;
    localparam logic [12:0] NONE = 13'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0, hit_way = 1'b0;
    logic dirty0 = 1'b0, dirty1 = 1'b0, pmem_resp = 1'b0;
    logic mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag, load_valid;
    logic load_dirty, load_lru, dirty_in, lru_in, data_src_sel, pmem_addr_sel;
    logic [COUNT_W-1:0] hit_count, miss_count, wb_count;
    logic [12:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_control #(.COUNT_W(COUNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .hit           (hit),
        .hit_way       (hit_way),
        .dirty0        (dirty0),
        .dirty1        (dirty1),
        .pmem_resp     (pmem_resp),
        .mem_resp      (mem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .way_sel       (way_sel),
        .load_data     (load_data),
        .load_tag      (load_tag),
        .load_valid    (load_valid),
        .load_dirty    (load_dirty),
        .load_lru      (load_lru),
        .dirty_in      (dirty_in),
        .lru_in        (lru_in),
        .data_src_sel  (data_src_sel),
        .pmem_addr_sel (pmem_addr_sel)
`ifdef CACHE_PERF_COUNTERS_EN
       ,.hit_count     (hit_count),
        .miss_count    (miss_count),
        .wb_count      (wb_count)
`endif
    );

`ifndef CACHE_PERF_COUNTERS_EN
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

    assign outs = {mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag, load_valid,
                   load_dirty, load_lru, dirty_in, lru_in, data_src_sel, pmem_addr_sel};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic h, input logic hw,
                          input logic d0, input logic d1, input logic pr);
        mem_read  = rd;
        mem_write = wr;
        hit       = h;
        hit_way   = hw;
        dirty0    = d0;
        dirty1    = d1;
        pmem_resp = pr;
        #1;
    endtask

    task automatic check_counters(input string tag, input int h, input int m, input int w);
`ifdef CACHE_PERF_COUNTERS_EN
        check({tag, "_hit_count"},  32'(hit_count),  32'(h));
        check({tag, "_miss_count"}, 32'(miss_count), 32'(m));
        check({tag, "_wb_count"},   32'(wb_count),   32'(w));
`else
        if (h < 0 || m < 0 || w < 0) $display("negative counter expectation in %s", tag);
`endif
    endtask

    initial begin
        // Reset holds every output low even with a hitting request present.
        set_in(1, 0, 1, 1, 0, 0, 1);
        check("reset_outs", 32'(outs), 32'(NONE));
        cyc();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("idle_outs", 32'(outs), 32'(NONE));
        check_counters("after_reset", 0, 0, 0);
        cyc();

        // Read hit on way 1.
        set_in(1, 0, 1, 1, 0, 0, 0);
        check("read_hit_w1", 32'(outs), 32'(MR | LLRU));
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("read_hit_state", 32'(dut.state_q), 32'(CHECK));

        // Write hit on way 0.
        set_in(0, 1, 1, 0, 0, 0, 0);
        check("write_hit_w0", 32'(outs), 32'(MR | LD | LDY | DIN | LLRU | LRUI));
        cyc();

        // Clean read miss, victim way 1; hit_way wiggles during the miss and must be ignored.
        set_in(1, 0, 0, 1, 1, 0, 0);
        check("clean_miss_c0", 32'(outs), 32'(NONE));
        cyc();
        for (int c = 1; c <= 4; c++) begin
            set_in(1, 0, 0, 0, 1, 0, 0);
            check($sformatf("clean_alloc_c%0d", c), 32'(outs), 32'(PR | WS));
            cyc();
        end
        set_in(1, 0, 0, 0, 1, 0, 1);
        check("clean_alloc_c5", 32'(outs), 32'(PR | WS | LD | LT | LV | LDY | DSS));
        cyc();
        set_in(1, 0, 1, 1, 1, 0, 0);
        check("clean_done_c6", 32'(outs), 32'(MR | LLRU));
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check_counters("after_clean", 2, 1, 0);

        // Dirty write miss, victim way 0.
        set_in(0, 1, 0, 0, 1, 0, 0);
        check("dirty_miss_c0", 32'(outs), 32'(NONE));
        cyc();
        set_in(0, 1, 0, 1, 1, 0, 0);
        check("wb_c1", 32'(outs), 32'(PW | PAS));
        cyc();
        set_in(0, 1, 0, 1, 1, 0, 1);
        check("wb_c2_resp", 32'(outs), 32'(PW | PAS));
        cyc();
        set_in(0, 1, 0, 1, 1, 0, 0);
        check("alloc_c3", 32'(outs), 32'(PR));
        cyc();
        set_in(0, 1, 0, 1, 1, 0, 1);
        check("alloc_c4_resp", 32'(outs), 32'(PR | LD | LT | LV | LDY | DSS));
        cyc();
        set_in(0, 1, 1, 0, 0, 0, 0);
        check("dirty_done_c5", 32'(outs), 32'(MR | LD | LDY | DIN | LLRU | LRUI));
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check_counters("after_dirty", 2, 2, 1);

        // Async reset mid-ALLOCATE.
        set_in(1, 0, 0, 1, 0, 0, 0);
        cyc();
        set_in(1, 0, 0, 1, 0, 0, 0);
        check("pre_rst_alloc", 32'(outs), 32'(PR | WS));
        rst = 1'b1;
        #1;
        check("rst_mid_outs", 32'(outs), 32'(NONE));
        check("rst_mid_state", 32'(dut.state_q), 32'(CHECK));
        check_counters("rst_mid", 0, 0, 0);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_idle", 32'(outs), 32'(NONE));
        cyc();

        // Stray pmem_resp in CHECK.
        set_in(0, 0, 0, 0, 0, 0, 1);
        check("stray_resp_outs", 32'(outs), 32'(NONE));
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("stray_resp_state", 32'(dut.state_q), 32'(CHECK));
        check("stray_resp_outs2", 32'(outs), 32'(NONE));

        // Request dropped during writeback: burst completes and returns via ALLOCATE.
        set_in(1, 0, 0, 1, 0, 1, 0);
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("drop_wb", 32'(outs), 32'(PW | PAS | WS));
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 1);
        check("drop_wb_resp", 32'(outs), 32'(PW | PAS | WS));
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 1);
        check("drop_alloc_resp", 32'(outs), 32'(PR | WS | LD | LT | LV | LDY | DSS));
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("drop_back_check", 32'(dut.state_q), 32'(CHECK));
        check("drop_idle_outs", 32'(outs), 32'(NONE));
        check_counters("after_drop", 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_control.md
# cache_control

Control FSM for the 2-way set-associative L1 cache. Consumes the per-access hit result and hit/victim way from the cache's hit-detection logic, then sequences the datapath and the physical-memory handshake. It handles read and write hits, dirty-victim writeback and line allocation. It sits between the CPU-side request port and the pmem port, alongside the cache datapath.

## Interface
Parameters:
- `COUNT_W`, 32: width of the performance counters (only used when the counter feature is compiled in).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`, `mem_write`  in  1 each  CPU request; held stable until `mem_resp`; never asserted together.
- `hit`  in  1  current set hits in either way.
- `hit_way`  in  1  hit way on a hit; LRU victim way on a miss.
- `dirty0`, `dirty1`  in  1 each  dirty bits of the indexed set.
- `pmem_resp`  in  1  physical memory has completed the current burst.
- `mem_resp`  out  1  CPU request complete.
- `pmem_read`, `pmem_write`  out  1 each  pmem request; held until `pmem_resp`.
- `way_sel`  out  1  way written by the load strobes.
- `load_data`, `load_tag`, `load_valid`, `load_dirty`, `load_lru`  out  1 each  array write strobes.
- `dirty_in`, `lru_in`  out  1 each  values for the dirty and LRU arrays.
- `data_src_sel`  out  1  0: CPU write data merged; 1: pmem line.
- `pmem_addr_sel`  out  1  0: CPU address; 1: {victim tag, index} for writeback.
- `hit_count`, `miss_count`, `wb_count`  out  `COUNT_W` each  present only with `CACHE_PERF_COUNTERS_EN`.

## Operation
- States: CHECK (reset/idle), WRITEBACK, ALLOCATE. All outputs are combinational from the state and inputs. Every output defaults to 0.
- CHECK, no request: stay; outputs all 0.
- CHECK, read hit:
  - `mem_resp`=1; `load_lru`=1; `lru_in`=~`hit_way`; stay in CHECK.
- CHECK, write hit:
  - `mem_resp`=1; `way_sel`=`hit_way`; `load_data`=1; `data_src_sel`=0; `load_dirty`=1; `dirty_in`=1.
  - LRU update as for a read hit; stay in CHECK.
- CHECK, miss (`hit`=0 with a request): victim is `hit_way`.
  - If the victim's dirty bit is 1, go to WRITEBACK.
  - Otherwise go to ALLOCATE.
  - No strobes and no `mem_resp` in this cycle.
- WRITEBACK:
  - `pmem_write`=1, `pmem_addr_sel`=1, `way_sel`=victim.
  - On `pmem_resp`, go to ALLOCATE.
- ALLOCATE:
  - `pmem_read`=1, `pmem_addr_sel`=0, `way_sel`=victim.
  - On `pmem_resp`: `load_data`=1, `data_src_sel`=1, `load_tag`=1, `load_valid`=1, `load_dirty`=1, `dirty_in`=0; go to CHECK.
  - The access then re-evaluates as a hit.
- The victim way is registered on entry to WRITEBACK/ALLOCATE and is used for the whole miss. `hit_way` is not re-sampled during the miss.
- Boundary conditions:
  - `pmem_resp` in CHECK: ignored.
  - A CPU request dropped mid-miss (protocol violation): the current pmem burst still completes and the FSM returns to CHECK via ALLOCATE. pmem handshakes are never aborted.
  - `rst` asserted in any state: the FSM immediately enters CHECK, all outputs go to 0 and the counters clear, without waiting for a clock edge.

## Timing
- Hit latency: `mem_resp` in the same cycle the request is presented (0 wait states).
- Clean miss, request at cycle 0:
  - Cycle 1: ALLOCATE with `pmem_read`.
  - `pmem_resp` at cycle N: line loaded at the end of cycle N.
  - Cycle N+1: CHECK hit with `mem_resp`.
- Dirty miss: WRITEBACK from cycle 1 until its `pmem_resp`, then ALLOCATE from the following cycle; otherwise as for a clean miss.
- `pmem_read` and `pmem_write` are never high in the same cycle.

## Configuration
- `CACHE_PERF_COUNTERS_EN` defined:
  - `hit_count` increments on each `mem_resp` cycle that was a hit on first evaluation.
  - `miss_count` increments on each CHECK→WRITEBACK or CHECK→ALLOCATE transition.
  - `wb_count` increments on each WRITEBACK→ALLOCATE transition.
  - Counters wrap modulo 2^`COUNT_W` and clear on `rst`.
  - The hit that completes a miss is not counted as a hit.
- Undefined: counter ports and logic are absent; FSM behaviour is identical.

## Structure
- Shared package `cache_types`: the state enum `cache_state_t` {CHECK, WRITEBACK, ALLOCATE}, and the mux-select constants `SRC_CPU`/`SRC_PMEM` and `ADDR_CPU`/`ADDR_WB`.
- One sub-module, `cache_perf_counters`, instantiated only under the macro. It takes the FSM events as inputs and drives the three counters.

## Test plan
- Reset, then read hit on way 1 → `mem_resp`=1 in the same cycle, `load_lru`=1, `lru_in`=0, state stays CHECK.
- Write hit on way 0 → `load_data`=1, `load_dirty`=1, `dirty_in`=1, `way_sel`=0, `mem_resp`=1.
- Clean read miss, victim 1, `pmem_resp` 5 cycles later → `pmem_read` high for cycles 1–5, load strobes in cycle 5, `mem_resp` in cycle 6.
- Dirty write miss, victim 0 (`dirty0`=1) → `pmem_write` with `pmem_addr_sel`=1 until `pmem_resp`, then `pmem_read`, then `mem_resp`; `wb_count`=1 and `miss_count`=1 with the macro defined.
- `rst` pulsed mid-ALLOCATE → `pmem_read` drops without a clock edge, state is CHECK, counters are 0.
- Stray `pmem_resp` in CHECK with no request → no strobes, no state change.
